// File: rtl/trdb_packet_scheduler.sv
// ---------------------------------------------------------------------------
// trdb_packet_scheduler
//
// Arbitrates between NUM_SRC trace packet sources and serializes the granted
// packet onto a BEAT_W-wide stream: one header beat {zeros, length, type}
// followed by ceil(length*8/BEAT_W) payload beats. Bytes at or beyond the
// packet length read as zero. One packet is held at a time; the scheduler is
// the only driver of the sink.
//
// Optional feature macro: TRDB_SCHED_PRIO_EN
//   defined   -> source 0 has strict priority, others round-robin among
//                themselves when source 0 is not requesting.
//   undefined -> plain round-robin across all sources.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   enable_i           allows new grants
//   src_valid_i/ready  per-source handshake (ready is one-hot or zero)
//   src_type_i         packed per-source packet type
//   src_length_i       packed per-source payload byte count
//   src_payload_i      packed per-source payload, byte 0 in LSBs
//   beat_valid_o/ready output beat handshake
//   beat_data_o        output beat
//   beat_last_o        final beat of the packet
//   busy_o             a packet is held
//   len_err_o          one-cycle pulse: accepted length was clamped
// ---------------------------------------------------------------------------
// state     | meaning
// S_IDLE    | no packet held, may grant a source
// S_HEADER  | presenting header beat
// S_PAYLOAD | presenting payload beat cnt
// ---------------------------------------------------------------------------
module trdb_packet_scheduler #(
    parameter int NUM_SRC   = 2,
    parameter int TYPE_W    = 2,
    parameter int LEN_W     = 5,
    parameter int PAYLOAD_W = 128,
    parameter int BEAT_W    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    input  logic [NUM_SRC*TYPE_W-1:0]    src_type_i,
    input  logic [NUM_SRC*LEN_W-1:0]     src_length_i,
    input  logic [NUM_SRC*PAYLOAD_W-1:0] src_payload_i,
    output logic                         beat_valid_o,
    input  logic                         beat_ready_i,
    output logic [BEAT_W-1:0]            beat_data_o,
    output logic                         beat_last_o,
    output logic                         busy_o,
    output logic                         len_err_o
);

    localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BEAT_B     = BEAT_W / 8;
    localparam int MAX_BYTES  = PAYLOAD_W / 8;
    localparam int NBEATS_MAX = PAYLOAD_W / BEAT_W;
    localparam int CNT_W      = $clog2(NBEATS_MAX) + 1;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [TYPE_W-1:0]      cap_type_q;
    logic [LEN_W-1:0]       cap_len_q;
    logic [PAYLOAD_W-1:0]   cap_payload_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   len_err_q;

    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   grant;
    logic [TYPE_W-1:0]      sel_type;
    logic [LEN_W-1:0]       sel_len;
    logic [PAYLOAD_W-1:0]   sel_payload;
    logic                   sel_too_long;
    logic                   pay_last;
    logic [BEAT_W-1:0]      pay_beat;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
`ifdef TRDB_SCHED_PRIO_EN
        // Source 0 wins outright; gnt_idx is already 0.
        if (src_valid_i[0]) begin
            gnt_any = 1'b1;
        end
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!gnt_any && (idx != 0) && src_valid_i[IDX_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
`else
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!gnt_any && src_valid_i[IDX_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
`endif
    end

    assign grant        = (state_q == S_IDLE) && enable_i && gnt_any;
    assign sel_type     = src_type_i[gnt_idx*TYPE_W +: TYPE_W];
    assign sel_len      = src_length_i[gnt_idx*LEN_W +: LEN_W];
    assign sel_payload  = src_payload_i[gnt_idx*PAYLOAD_W +: PAYLOAD_W];
    assign sel_too_long = ({1'b0, sel_len} > MAX_LEN);

    // Last payload beat index is ceil(len / BEAT_B) - 1.
    always_comb begin
        int nbeats;
        nbeats   = (int'(cap_len_q) + BEAT_B - 1) / BEAT_B;
        pay_last = (int'(cnt_q) == nbeats - 1);
    end

    // Current payload beat with bytes past the packet length forced to zero.
    always_comb begin
        pay_beat = cap_payload_q[int'(cnt_q)*BEAT_W +: BEAT_W];
        for (int b = 0; b < BEAT_B; b++) begin
            if ((int'(cnt_q) * BEAT_B + b) >= int'(cap_len_q)) begin
                pay_beat[b*8 +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (beat_ready_i) state_d = (cap_len_q == '0) ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (beat_ready_i && pay_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready_o  = '0;
        beat_valid_o = 1'b0;
        beat_data_o  = '0;
        beat_last_o  = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (grant) src_ready_o[gnt_idx] = 1'b1;
            end
            S_HEADER: begin
                beat_valid_o                    = 1'b1;
                beat_data_o[TYPE_W-1:0]         = cap_type_q;
                beat_data_o[TYPE_W +: LEN_W]    = cap_len_q;
                beat_last_o                     = (cap_len_q == '0);
            end
            S_PAYLOAD: begin
                beat_valid_o = 1'b1;
                beat_data_o  = pay_beat;
                beat_last_o  = pay_last;
            end
            default: ;
        endcase
    end

    assign len_err_o = len_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q      <= IDX_W'(NUM_SRC - 1);
            cap_type_q    <= '0;
            cap_len_q     <= '0;
            cap_payload_q <= '0;
            cnt_q         <= '0;
            len_err_q     <= 1'b0;
        end else begin
            len_err_q <= grant && sel_too_long;
            if (grant) begin
                rr_ptr_q      <= gnt_idx;
                cap_type_q    <= sel_type;
                cap_len_q     <= sel_too_long ? MAX_LEN[LEN_W-1:0] : sel_len;
                cap_payload_q <= sel_payload;
                cnt_q         <= '0;
            end else if (state_q == S_PAYLOAD && beat_ready_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed scoreboard bench for trdb_packet_scheduler. Stimulus pushes the
// expected grants and beats into queues; a negedge monitor pops and compares
// whenever the DUT hands over a beat or asserts a ready.
module tb_trdb_packet_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [1:0]   src_valid;
    logic [1:0]   src_ready;
    logic [3:0]   src_type;
    logic [9:0]   src_length;
    logic [255:0] src_payload;
    logic         beat_valid;
    logic         beat_ready;
    logic [31:0]  beat_data;
    logic         beat_last;
    logic         busy;
    logic         len_err;

    trdb_packet_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .src_valid_i   (src_valid),
        .src_ready_o   (src_ready),
        .src_type_i    (src_type),
        .src_length_i  (src_length),
        .src_payload_i (src_payload),
        .beat_valid_o  (beat_valid),
        .beat_ready_i  (beat_ready),
        .beat_data_o   (beat_data),
        .beat_last_o   (beat_last),
        .busy_o        (busy),
        .len_err_o     (len_err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] P1 = 128'hDEADBEEF_CAFEF00D_99887744_33221100;
    localparam logic [127:0] P2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] P3 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_beats  = 0;
    int busy_cnt = 0;
    int lerr_cnt = 0;
    int rdy0_cnt = 0;
    int prev_gnt_cyc = 0;
    int last_gnt_cyc = 0;

    logic [32:0] exp_beats[$];
    int          exp_gnt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic l);
        exp_beats.push_back({l, d});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (len_err) lerr_cnt++;
        if (rst_n && (src_ready != 2'b00)) begin
            check("ready_onehot", 64'($onehot(src_ready)), 64'd1);
            prev_gnt_cyc = last_gnt_cyc;
            last_gnt_cyc = cyc;
            if (src_ready[0]) rdy0_cnt++;
            if (exp_gnt.size() == 0) begin
                fail_now("unexpected_grant");
            end else begin
                check("grant", 64'(src_ready), 64'd1 << exp_gnt.pop_front());
            end
        end
        if (rst_n && beat_valid && beat_ready) begin
            n_beats++;
            if (exp_beats.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                check("beat", 64'({beat_last, beat_data}), 64'(exp_beats.pop_front()));
            end
        end
    end

    task automatic set_src(input int s, input logic [1:0] t, input logic [4:0] l,
                           input logic [127:0] p);
        src_type[s*2 +: 2]      = t;
        src_length[s*5 +: 5]    = l;
        src_payload[s*128 +: 128] = p;
    endtask

    // Entered at posedge+1; returns at posedge+1 right after the n-th grant edge
    // with all valids dropped.
    task automatic run_until_grants(input int n);
        int g;
        g = 0;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (src_ready != 2'b00) begin
                g++;
                if (g == n) begin
                    @(posedge clk); #1;
                    src_valid = 2'b00;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        src_valid = 2'b00;
        fail_now("grant_timeout");
    endtask

    task automatic send_pkt(input int s, input logic [1:0] t, input logic [4:0] l,
                            input logic [127:0] p);
        set_src(s, t, l, p);
        src_valid[s] = 1'b1;
        run_until_grants(1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        fail_now("idle_timeout");
    endtask

    task automatic wait_beats(input int target);
        for (int c = 0; c < 200; c++) begin
            if (n_beats >= target) return;
            @(posedge clk); #1;
        end
        fail_now("beat_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n       = 1'b0;
        enable      = 1'b1;
        src_valid   = 2'b00;
        src_type    = '0;
        src_length  = '0;
        src_payload = '0;
        beat_ready  = 1'b1;
        #2;
        check("rst_beat_valid", 64'(beat_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(beat_data), 64'd0);
        check("rst_last", 64'(beat_last), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_ready", 64'(src_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single packet, len 5, masking of the last beat
        busy_cnt = 0; rdy0_cnt = 0;
        exp_gnt.push_back(0);
        exp_beat(32'h00000016, 1'b0);
        exp_beat(32'h33221100, 1'b0);
        exp_beat(32'h00000044, 1'b1);
        send_pkt(0, 2'b10, 5'd5, P1);
        wait_idle();
        check("single_busy_cycles", 64'(busy_cnt), 64'd3);
        check("single_ready_cycles", 64'(rdy0_cnt), 64'd1);

        // Zero length, back-to-back from one source
        exp_gnt.push_back(1); exp_gnt.push_back(1);
        exp_beat(32'h00000001, 1'b1);
        exp_beat(32'h00000001, 1'b1);
        set_src(1, 2'b01, 5'd0, P1);
        src_valid = 2'b10;
        run_until_grants(2);
        wait_idle();
        check("zero_len_regrant_gap", 64'(last_gnt_cyc - prev_gnt_cyc), 64'd2);

        // Both sources continuously valid
`ifdef TRDB_SCHED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(0);
            exp_beat(32'h00000010, 1'b0);
            exp_beat(32'h33221100, 1'b1);
        end
`else
        for (int i = 0; i < 2; i++) begin
            exp_gnt.push_back(0);
            exp_beat(32'h00000010, 1'b0);
            exp_beat(32'h33221100, 1'b1);
            exp_gnt.push_back(1);
            exp_beat(32'h00000013, 1'b0);
            exp_beat(32'h03020100, 1'b1);
        end
`endif
        set_src(0, 2'b00, 5'd4, P1);
        set_src(1, 2'b11, 5'd4, P2);
        src_valid = 2'b11;
        run_until_grants(4);
        wait_idle();

        // Backpressure on the second payload beat, source data changed after grant
        exp_gnt.push_back(0);
        exp_beat(32'h00000031, 1'b0);
        exp_beat(32'h03020100, 1'b0);
        exp_beat(32'h07060504, 1'b0);
        exp_beat(32'h0B0A0908, 1'b1);
        send_pkt(0, 2'b01, 5'd12, P2);
        base = n_beats;
        wait_beats(base + 2);
        beat_ready = 1'b0;
        set_src(0, 2'b11, 5'd31, {128{1'b1}});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(beat_valid), 64'd1);
            check("bp_data", 64'(beat_data), 64'h07060504);
            check("bp_last", 64'(beat_last), 64'd0);
        end
        @(posedge clk); #1;
        beat_ready = 1'b1;
        wait_idle();

        // Length clamp
        check("no_len_err_before_clamp", 64'(lerr_cnt), 64'd0);
        lerr_cnt = 0;
        exp_gnt.push_back(1);
        exp_beat(32'h00000042, 1'b0);
        exp_beat(32'h33221100, 1'b0);
        exp_beat(32'h77665544, 1'b0);
        exp_beat(32'hBBAA9988, 1'b0);
        exp_beat(32'hFFEEDDCC, 1'b1);
        send_pkt(1, 2'b10, 5'd20, P3);
        check("len_err_after_grant", 64'(len_err), 64'd1);
        wait_idle();
        check("len_err_pulses", 64'(lerr_cnt), 64'd1);

        // Enable dropped mid-packet
        exp_gnt.push_back(0);
        exp_beat(32'h00000020, 1'b0);
        exp_beat(32'h03020100, 1'b0);
        exp_beat(32'h07060504, 1'b1);
        send_pkt(0, 2'b00, 5'd8, P2);
        base = n_beats;
        wait_beats(base + 1);
        enable    = 1'b0;
        src_valid = 2'b11;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("disabled_ready", 64'(src_ready), 64'd0);
            check("disabled_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        src_valid = 2'b00;
        enable    = 1'b1;

        // Reset mid-packet, then pointer back to its reset value
        exp_gnt.push_back(0);
        exp_beat(32'h00000030, 1'b0);
        exp_beat(32'h03020100, 1'b0);
        exp_beat(32'h07060504, 1'b0);
        exp_beat(32'h0B0A0908, 1'b1);
        send_pkt(0, 2'b00, 5'd12, P2);
        base = n_beats;
        wait_beats(base + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(beat_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(beat_data), 64'd0);
        check("midrst_last", 64'(beat_last), 64'd0);
        exp_beats.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_gnt.push_back(0);
        exp_beat(32'h00000010, 1'b0);
        exp_beat(32'h33221100, 1'b1);
        set_src(0, 2'b00, 5'd4, P1);
        set_src(1, 2'b01, 5'd4, P1);
        src_valid = 2'b11;
        run_until_grants(1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("grants_drained", 64'(exp_gnt.size()), 64'd0);
        check("beats_drained", 64'(exp_beats.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
